dmrl3_signal_checker: RTL and testbench
=======================================

DMRL3_SIGNAL_CHECKER -- requirements
Module: dmrl3_signal_checker

Interface
REQ-001 Parameter TOL, default 2, allowed deviation in clk cycles for every edge and for the period.
REQ-002 Parameter PERIOD, default 15001, nominal frame length in clk cycles, measured sinhr-rise to sinhr-rise.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 upr_mod  input  1  modulator control pulse train from the dmrl3 signal generator.
REQ-006 upr_gen  input  1  generator control pulse train.
REQ-007 sinhr  input  1  frame sync pulse; its rising edge marks frame start.
REQ-008 frame_done  output  1  one-cycle pulse when a frame verdict is issued.
REQ-009 frame_ok  output  1  verdict of the last frame; valid from frame_done until the next frame_done.
REQ-010 err_flags  output  4  last-frame errors: [0] mod, [1] gen, [2] sinhr width, [3] period/timeout.
REQ-011 frame_cnt  output  16  frames evaluated since reset; saturates at 65535.
REQ-012 err_cnt  output  16  frames with any error since reset; saturates at 65535.
REQ-013 locked  output  1  high after 4 consecutive error-free frames; low on any error frame.

Function
REQ-014 Inputs pass through a 2-FF synchronizer, then a 1-FF edge detector; all three channels get identical delay.
REQ-015 FSM states: SEEK (wait for the first sinhr rise) and RUN (frame in progress); reset enters SEEK.
REQ-016 SEEK->RUN on a sinhr rise: cnt is cleared to 0 and per-frame edge indices and error bits are cleared.
REQ-017 In RUN, cnt increments by 1 per cycle; cnt is 15 bits wide.
REQ-018 Events in the cycle of a sinhr rise belong to the new frame at time 0.
REQ-019 Expected upr_mod edges (rise/fall alternating, starting high at 0): 0, 13, 406, 506, 1856, 3056.
REQ-020 Expected upr_gen edges (rise first): 21, 34, 424, 528, 1876, 3088.
REQ-021 Expected sinhr fall: 50.
REQ-022 The k-th detected edge of a channel is compared to table entry k; |cnt - exp| > TOL sets that channel's error bit.
REQ-023 An edge of the wrong polarity, or an edge beyond the 6th, sets that channel's error bit.
REQ-024 Fewer than 6 edges on a channel at frame end sets that channel's error bit.
REQ-025 The upr_mod rise at time 0 is exempt from the timing check but is counted as edge 0.
REQ-026 A sinhr rise with cnt outside PERIOD-1 +/- TOL sets bit 3.
REQ-027 On a sinhr rise, the current frame is evaluated, frame_done pulses, and the FSM stays in RUN with cnt restarted.
REQ-028 If cnt reaches PERIOD+TOL with no sinhr rise: set bit 3, issue frame_done, then enter SEEK.
REQ-029 frame_done and outputs update in the cycle after the terminating event.
REQ-030 frame_ok = (err_flags == 0).
REQ-031 The first frame after SEEK produces no verdict until its terminating sinhr rise or timeout.

Reset
REQ-032 On rst, all outputs are 0, synchronizer FFs are 0, the FSM is in SEEK, and all counters are cleared.
REQ-033 An rst assertion mid-frame aborts the frame without issuing frame_done.
REQ-034 The edge detector suppresses edges for the first cycle after reset release.

Structure
REQ-035 Package dmrl3_pkg holds the edge tables, PERIOD default, the err_flags bit indices, the FSM state enum and counter widths.
REQ-036 Sub-module dmrl3_edge_checker (edge index, polarity, window compare, error bit) is instantiated for upr_mod and upr_gen.

Verification
REQ-037 Ideal generator waveforms for 5 frames -> frame_done every 15001 cycles, frame_ok=1, err_flags=0, frame_cnt=4, locked=1 after the 4th verdict.
REQ-038 upr_gen fall at 533 instead of 528 -> err_flags=4'b0010, err_cnt increments, locked=0.
REQ-039 1-cycle glitch on upr_mod at 8000 -> err_flags[0]=1.
REQ-040 sinhr stops after a frame -> frame_done at cnt=15003 with err_flags[3]=1, FSM in SEEK.
REQ-041 Period 14990 -> err_flags[3]=1; sinhr width 60 -> err_flags[2]=1.
REQ-042 rst at cnt=2000 -> all outputs 0 next cycle, no frame_done; the next sinhr rise restarts checking.

Source files
------------

// File: rtl/dmrl3_pkg.sv
// dmrl3_pkg
//   Shared definitions for the dmrl3 signal checker: counter widths,
//   nominal timing defaults, expected edge tables for upr_mod / upr_gen,
//   err_flags bit positions and the frame FSM state type.
package dmrl3_pkg;

  localparam int CNT_W          = 15;     // in-frame cycle counter
  localparam int STAT_W         = 16;     // saturating frame/error counters
  localparam int IDX_W          = 3;      // per-channel edge index
  localparam int N_EDGES        = 6;      // edges expected per channel per frame
  localparam int PERIOD_DEFAULT = 15001;
  localparam int TOL_DEFAULT    = 2;
  localparam int SINHR_FALL     = 50;     // expected sinhr fall time
  localparam int LOCK_FRAMES    = 4;      // clean frames needed for lock

  // err_flags bit positions
  localparam int ERR_MOD    = 0;
  localparam int ERR_GEN    = 1;
  localparam int ERR_SINHR  = 2;
  localparam int ERR_PERIOD = 3;

  // channel selectors for the edge tables
  localparam int CH_MOD = 0;
  localparam int CH_GEN = 1;

  typedef enum logic {
    SEEK = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Expected time of the idx-th edge on a channel. Even indices are rises.
  function automatic int exp_edge(input int ch, input logic [IDX_W-1:0] idx);
    int t;
    t = 0;
    if (ch == CH_MOD) begin
      case (idx)
        3'd0:    t = 0;
        3'd1:    t = 13;
        3'd2:    t = 406;
        3'd3:    t = 506;
        3'd4:    t = 1856;
        3'd5:    t = 3056;
        default: t = 0;
      endcase
    end else begin
      case (idx)
        3'd0:    t = 21;
        3'd1:    t = 34;
        3'd2:    t = 424;
        3'd3:    t = 528;
        3'd4:    t = 1876;
        3'd5:    t = 3088;
        default: t = 0;
      endcase
    end
    return t;
  endfunction

  // True when t deviates from exp by more than tol in either direction.
  function automatic logic out_of_window(input int t, input int exp, input int tol);
    int d;
    d = t - exp;
    return (d > tol) || (d < -tol);
  endfunction

endpackage

// File: rtl/dmrl3_edge_checker.sv
// dmrl3_edge_checker
//   Tracks the edges of one control channel within a frame: edge index,
//   polarity, timing window against the channel's table, sticky error bit.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        frame starts this cycle (events here are time 0 of new frame)
//   active       frame in progress (events are checked)
//   rise, fall   detected edges of the channel this cycle
//   cnt_time     frame time of this cycle
//   frame_err    error verdict of the frame held so far (incl. missing edges)
module dmrl3_edge_checker
  import dmrl3_pkg::*;
#(
  parameter int CH           = CH_MOD,
  parameter int TOL          = TOL_DEFAULT,
  parameter bit EXEMPT_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             active,
  input  logic             rise,
  input  logic             fall,
  input  logic [CNT_W-1:0] cnt_time,
  output logic             frame_err
);

  logic [IDX_W-1:0] idx_reg, idx_next, base_idx;
  logic             err_reg, err_next, base_err;
  logic             exempt;

  always_comb begin
    // A start cycle discards the old frame before applying its own events.
    base_idx = start ? '0 : idx_reg;
    base_err = start ? 1'b0 : err_reg;
    idx_next = base_idx;
    err_next = base_err;
    exempt   = EXEMPT_FIRST && (base_idx == '0);
    if ((start || active) && (rise || fall)) begin
      if (int'(base_idx) >= N_EDGES) begin
        err_next = 1'b1;
      end else begin
        idx_next = base_idx + IDX_W'(1);
        // Even index expects a rise: bit 0 equal to rise means wrong polarity.
        if (rise == base_idx[0]) begin
          err_next = 1'b1;
        end else if (!exempt &&
                     out_of_window(int'(cnt_time), exp_edge(CH, base_idx), TOL)) begin
          err_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      idx_reg <= idx_next;
      err_reg <= err_next;
    end
  end

  assign frame_err = err_reg || (idx_reg != IDX_W'(N_EDGES));

endmodule

// File: rtl/dmrl3_signal_checker.sv
// dmrl3_signal_checker
//   Checks the dmrl3 generator outputs frame by frame against the nominal
//   timing tables and reports a verdict per frame plus running statistics.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   upr_mod, upr_gen    control pulse trains under test
//   sinhr               frame sync; rise marks frame start
//   frame_done          one-cycle verdict pulse
//   frame_ok            last verdict clean (err_flags == 0)
//   err_flags[3:0]      last-frame errors: mod, gen, sinhr width, period/timeout
//   frame_cnt, err_cnt  saturating counts of evaluated / failed frames
//   locked              LOCK_FRAMES consecutive clean frames seen
module dmrl3_signal_checker
  import dmrl3_pkg::*;
#(
  parameter int TOL    = TOL_DEFAULT,
  parameter int PERIOD = PERIOD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upr_mod,
  input  logic              upr_gen,
  input  logic              sinhr,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [3:0]        err_flags,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic              locked
);

  localparam int NCH      = 3;
  localparam int CH_SINHR = 2;
  localparam int WIN_LO   = PERIOD - 1 - TOL;
  localparam int WIN_HI   = PERIOD - 1 + TOL;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(PERIOD + TOL);

  logic [NCH-1:0] in_vec, rise_vec, fall_vec;
  logic           edge_en_reg;

  assign in_vec = {sinhr, upr_gen, upr_mod};

  // Blocks edges in the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst) edge_en_reg <= 1'b0;
    else     edge_en_reg <= 1'b1;
  end

  // Identical 2-FF synchronizer + edge detector on every channel so the
  // relative timing between channels is preserved.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_sync
      logic s1_reg, s2_reg, prev_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          s1_reg   <= in_vec[gi];
          s2_reg   <= s1_reg;
          prev_reg <= s2_reg;
        end
      end
      assign rise_vec[gi] = edge_en_reg &&  s2_reg && !prev_reg;
      assign fall_vec[gi] = edge_en_reg && !s2_reg &&  prev_reg;
    end
  endgenerate

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_time;
  logic               sinhr_seen_reg, sinhr_err_reg;
  logic [2:0]         ok_streak_reg;
  logic               sinhr_rise, sinhr_fall, timeout_hit, chk_active, verdict;
  logic               period_bad;
  logic [1:0]         chk_err;
  logic [3:0]         verdict_flags;

  assign sinhr_rise  = rise_vec[CH_SINHR];
  assign sinhr_fall  = fall_vec[CH_SINHR];
  assign timeout_hit = (state_reg == RUN) && !sinhr_rise && (cnt_reg == TIMEOUT_CNT);
  assign chk_active  = (state_reg == RUN) && !timeout_hit;
  assign verdict     = (state_reg == RUN) && (sinhr_rise || timeout_hit);
  // cnt_reg is cleared in the cycle after the sinhr rise, so the frame time
  // of a cycle is cnt_reg + 1 (0 in the rise cycle itself).
  assign cnt_time    = sinhr_rise ? '0 : cnt_reg + CNT_W'(1);
  assign period_bad  = (int'(cnt_reg) < WIN_LO) || (int'(cnt_reg) > WIN_HI);

  generate
    for (gi = 0; gi < 2; gi++) begin : g_chk
      dmrl3_edge_checker #(
        .CH          (gi),
        .TOL         (TOL),
        .EXEMPT_FIRST(gi == CH_MOD)
      ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .start    (sinhr_rise),
        .active   (chk_active),
        .rise     (rise_vec[gi]),
        .fall     (fall_vec[gi]),
        .cnt_time (cnt_time),
        .frame_err(chk_err[gi])
      );
    end
  endgenerate

  always_comb begin
    verdict_flags             = '0;
    verdict_flags[ERR_MOD]    = chk_err[CH_MOD];
    verdict_flags[ERR_GEN]    = chk_err[CH_GEN];
    verdict_flags[ERR_SINHR]  = sinhr_err_reg || !sinhr_seen_reg;
    verdict_flags[ERR_PERIOD] = timeout_hit || period_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SEEK;
      cnt_reg        <= '0;
      sinhr_seen_reg <= 1'b0;
      sinhr_err_reg  <= 1'b0;
      ok_streak_reg  <= '0;
      frame_done     <= 1'b0;
      frame_ok       <= 1'b0;
      err_flags      <= '0;
      frame_cnt      <= '0;
      err_cnt        <= '0;
      locked         <= 1'b0;
    end else begin
      frame_done <= verdict;
      if (verdict) begin
        err_flags <= verdict_flags;
        frame_ok  <= (verdict_flags == '0);
        if (frame_cnt != '1) frame_cnt <= frame_cnt + STAT_W'(1);
        if (verdict_flags != '0) begin
          if (err_cnt != '1) err_cnt <= err_cnt + STAT_W'(1);
          ok_streak_reg <= '0;
          locked        <= 1'b0;
        end else begin
          if (ok_streak_reg < 3'(LOCK_FRAMES)) ok_streak_reg <= ok_streak_reg + 3'd1;
          if (ok_streak_reg >= 3'(LOCK_FRAMES - 1)) locked <= 1'b1;
        end
      end

      if (sinhr_rise) begin
        state_reg      <= RUN;
        cnt_reg        <= '0;
        sinhr_seen_reg <= 1'b0;
        sinhr_err_reg  <= 1'b0;
      end else if (timeout_hit) begin
        state_reg <= SEEK;
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        // Only the first sinhr fall of a frame defines its width.
        if (sinhr_fall && !sinhr_seen_reg) begin
          sinhr_seen_reg <= 1'b1;
          sinhr_err_reg  <= out_of_window(int'(cnt_time), SINHR_FALL, TOL);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmrl3_signal_checker.sv
// tb_dmrl3_signal_checker
//   Directed bench: drives ideal and deliberately distorted dmrl3 frames
//   and checks verdicts, counters, lock and reset behaviour. A shortened
//   frame period keeps the run compact; edge tables are unchanged.
module tb_dmrl3_signal_checker;

  localparam int P   = 3201;
  localparam int TOL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upr_mod = 1'b0;
  logic        upr_gen = 1'b0;
  logic        sinhr = 1'b0;
  logic        frame_done, frame_ok, locked;
  logic [3:0]  err_flags;
  logic [15:0] frame_cnt, err_cnt;

  dmrl3_signal_checker #(.TOL(TOL), .PERIOD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .upr_mod   (upr_mod),
    .upr_gen   (upr_gen),
    .sinhr     (sinhr),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .err_flags (err_flags),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int mod_tbl[6] = '{0, 13, 406, 506, 1856, 3056};
  int gen_tbl[6] = '{21, 34, 424, 528, 1876, 3088};
  int glitch_at   = -1;
  int sinhr_width = 50;
  bit quiet       = 1'b1;
  int frame_t     = 0;
  int cyc         = 0;

  int          done_cnt = 0;
  int          cap_cyc  = 0;
  int          prev_cyc = 0;
  logic [3:0]  cap_flags = '0;
  logic        cap_ok = 1'b0;
  logic        cap_locked = 1'b0;
  logic [15:0] cap_fc = '0;
  logic [15:0] cap_ec = '0;

  function automatic logic lvl(input int which, input int t);
    int n = 0;
    for (int i = 0; i < 6; i++)
      if (((which == 0) ? mod_tbl[i] : gen_tbl[i]) <= t) n++;
    return (n % 2) == 1;
  endfunction

  // One clock: drive the waveform for frame_t, sample #1 after the edge.
  task automatic tick();
    if (quiet) begin
      upr_mod = 1'b0;
      upr_gen = 1'b0;
      sinhr   = 1'b0;
    end else begin
      upr_mod = lvl(0, frame_t) ^ (frame_t == glitch_at);
      upr_gen = lvl(1, frame_t);
      sinhr   = (frame_t < sinhr_width);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done === 1'b1) begin
      done_cnt++;
      prev_cyc   = cap_cyc;
      cap_cyc    = cyc;
      cap_flags  = err_flags;
      cap_ok     = frame_ok;
      cap_locked = locked;
      cap_fc     = frame_cnt;
      cap_ec     = err_cnt;
      $display("verdict @%0d flags=%b ok=%b frame_cnt=%0d err_cnt=%0d locked=%b",
               cyc, err_flags, frame_ok, frame_cnt, err_cnt, locked);
    end
    frame_t++;
  endtask

  task automatic run_frame(input int len);
    frame_t = 0;
    repeat (len) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet = 1'b1;
    repeat (3) tick();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL reset_ok: got %b want 0", frame_ok); end
    n_cmp++; if (err_flags !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", err_flags); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    rst = 1'b0;
    repeat (3) tick();
    quiet = 1'b0;
  endtask

  // Five ideal frames: four verdicts, all clean, spaced one period apart.
  task automatic test_ideal();
    int base;
    base = done_cnt;
    for (int i = 0; i < 5; i++) begin
      run_frame(P);
      n_cmp++; if (done_cnt - base !== i) begin n_bad++; $display("FAIL ideal_done_count: got %0d want %0d", done_cnt - base, i); end
      if (i >= 1) begin
        n_cmp++; if (cap_flags !== 4'b0000) begin n_bad++; $display("FAIL ideal_flags: got %b want 0000", cap_flags); end
        n_cmp++; if (cap_ok !== 1'b1) begin n_bad++; $display("FAIL ideal_ok: got %b want 1", cap_ok); end
      end
      if (i >= 2) begin
        n_cmp++; if (cap_cyc - prev_cyc !== P) begin n_bad++; $display("FAIL ideal_interval: got %0d want %0d", cap_cyc - prev_cyc, P); end
      end
      if (i == 3) begin
        n_cmp++; if (cap_locked !== 1'b0) begin n_bad++; $display("FAIL ideal_locked_early: got %b want 0", cap_locked); end
      end
      if (i == 4) begin
        n_cmp++; if (cap_locked !== 1'b1) begin n_bad++; $display("FAIL ideal_locked: got %b want 1", cap_locked); end
      end
    end
    n_cmp++; if (frame_cnt !== 16'd4) begin n_bad++; $display("FAIL ideal_frame_cnt: got %0d want 4", frame_cnt); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL ideal_err_cnt: got %0d want 0", err_cnt); end
  endtask

  // upr_gen fall at 533 instead of 528: only the gen bit is set.
  task automatic test_gen_shift();
    gen_tbl[3] = 533;
    run_frame(P);
    gen_tbl[3] = 528;
    run_frame(P);
    n_cmp++; if (cap_flags !== 4'b0010) begin n_bad++; $display("FAIL gen_flags: got %b want 0010", cap_flags); end
    n_cmp++; if (cap_ok !== 1'b0) begin n_bad++; $display("FAIL gen_ok: got %b want 0", cap_ok); end
    n_cmp++; if (cap_ec !== 16'd1) begin n_bad++; $display("FAIL gen_err_cnt: got %0d want 1", cap_ec); end
    n_cmp++; if (cap_fc !== 16'd6) begin n_bad++; $display("FAIL gen_frame_cnt: got %0d want 6", cap_fc); end
    n_cmp++; if (cap_locked !== 1'b0) begin n_bad++; $display("FAIL gen_locked: got %b want 0", cap_locked); end
  endtask

  // Extra 1-cycle pulse on upr_mod after its sixth edge.
  task automatic test_mod_glitch();
    glitch_at = 3150;
    run_frame(P);
    glitch_at = -1;
    run_frame(P);
    n_cmp++; if (cap_flags !== 4'b0001) begin n_bad++; $display("FAIL glitch_flags: got %b want 0001", cap_flags); end
    n_cmp++; if (cap_ec !== 16'd2) begin n_bad++; $display("FAIL glitch_err_cnt: got %0d want 2", cap_ec); end
    n_cmp++; if (cap_fc !== 16'd8) begin n_bad++; $display("FAIL glitch_frame_cnt: got %0d want 8", cap_fc); end
  endtask

  // Frame 11 cycles short: period bit only.
  task automatic test_period_short();
    run_frame(P - 11);
    run_frame(P);
    n_cmp++; if (cap_flags !== 4'b1000) begin n_bad++; $display("FAIL short_flags: got %b want 1000", cap_flags); end
    n_cmp++; if (cap_cyc - prev_cyc !== P - 11) begin n_bad++; $display("FAIL short_interval: got %0d want %0d", cap_cyc - prev_cyc, P - 11); end
    n_cmp++; if (cap_ec !== 16'd3) begin n_bad++; $display("FAIL short_err_cnt: got %0d want 3", cap_ec); end
  endtask

  // sinhr 60 cycles wide instead of 50: sinhr width bit only.
  task automatic test_sinhr_width();
    sinhr_width = 60;
    run_frame(P);
    sinhr_width = 50;
    run_frame(P);
    n_cmp++; if (cap_flags !== 4'b0100) begin n_bad++; $display("FAIL width_flags: got %b want 0100", cap_flags); end
    n_cmp++; if (cap_fc !== 16'd12) begin n_bad++; $display("FAIL width_frame_cnt: got %0d want 12", cap_fc); end
    n_cmp++; if (cap_ec !== 16'd4) begin n_bad++; $display("FAIL width_err_cnt: got %0d want 4", cap_ec); end
  endtask

  // The pending ideal frame never sees its terminating sinhr rise.
  task automatic test_timeout();
    int base;
    base = done_cnt;
    quiet = 1'b1;
    run_frame(P + 20);
    n_cmp++; if (done_cnt - base !== 1) begin n_bad++; $display("FAIL timeout_done_count: got %0d want 1", done_cnt - base); end
    n_cmp++; if (cap_flags !== 4'b1000) begin n_bad++; $display("FAIL timeout_flags: got %b want 1000", cap_flags); end
    // Normal verdict follows cnt=P-1 by one cycle; timeout follows cnt=P+TOL.
    n_cmp++; if (cap_cyc - prev_cyc !== P + TOL + 1) begin n_bad++; $display("FAIL timeout_interval: got %0d want %0d", cap_cyc - prev_cyc, P + TOL + 1); end
    n_cmp++; if (cap_fc !== 16'd13) begin n_bad++; $display("FAIL timeout_frame_cnt: got %0d want 13", cap_fc); end
    n_cmp++; if (dut.state_reg !== dmrl3_pkg::SEEK) begin n_bad++; $display("FAIL timeout_state: got %b want SEEK", dut.state_reg); end
  endtask

  // Reset mid-frame, then checking restarts from the next sinhr rise.
  task automatic test_rst_mid();
    int base;
    base = done_cnt;
    quiet = 1'b0;
    frame_t = 0;
    repeat (2001) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
    n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL rst_ok: got %b want 0", frame_ok); end
    n_cmp++; if (err_flags !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", err_flags); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    rst = 1'b0;
    repeat (P - 2002) tick();
    n_cmp++; if (done_cnt !== base) begin n_bad++; $display("FAIL rst_no_verdict: got %0d want %0d", done_cnt, base); end
    run_frame(P);
    n_cmp++; if (done_cnt !== base) begin n_bad++; $display("FAIL rst_first_frame: got %0d want %0d", done_cnt, base); end
    run_frame(10);
    n_cmp++; if (done_cnt !== base + 1) begin n_bad++; $display("FAIL rst_restart_done: got %0d want %0d", done_cnt, base + 1); end
    n_cmp++; if (cap_flags !== 4'b0000) begin n_bad++; $display("FAIL rst_restart_flags: got %b want 0000", cap_flags); end
    n_cmp++; if (cap_ok !== 1'b1) begin n_bad++; $display("FAIL rst_restart_ok: got %b want 1", cap_ok); end
    n_cmp++; if (cap_fc !== 16'd1) begin n_bad++; $display("FAIL rst_restart_frame_cnt: got %0d want 1", cap_fc); end
    n_cmp++; if (cap_ec !== 16'd0) begin n_bad++; $display("FAIL rst_restart_err_cnt: got %0d want 0", cap_ec); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_gen_shift();
    test_mod_glitch();
    test_period_short();
    test_sinhr_width();
    test_timeout();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
